// File: rtl/rename_map_nw.sv
// N-wide register rename map: speculative RAT, architectural RAT and a
// circular free list. Renames up to WIDTH instructions per cycle with
// intra-group RAW/WAW bypass, retires up to CWIDTH per cycle, and recovers
// from a flush in one cycle by copying the architectural state back.
module rename_map_nw #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    parameter int WIDTH     = 2,
    parameter int CWIDTH    = 2,
    parameter int ARCH_W    = $clog2(ARCH_REGS),
    parameter int PHYS_W    = $clog2(PHYS_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         ren_valid,
    output logic                     ren_ready,
    input  logic [WIDTH-1:0]         ren_uses_rd,
    input  logic [WIDTH*ARCH_W-1:0]  ren_rd_arch,
    input  logic [WIDTH*ARCH_W-1:0]  ren_rs1_arch,
    input  logic [WIDTH*ARCH_W-1:0]  ren_rs2_arch,
    output logic [WIDTH*PHYS_W-1:0]  ren_rs1_phys,
    output logic [WIDTH*PHYS_W-1:0]  ren_rs2_phys,
    output logic [WIDTH*PHYS_W-1:0]  ren_pd_new,
    output logic [WIDTH*PHYS_W-1:0]  ren_pd_old,
    input  logic [CWIDTH-1:0]        cmt_valid,
    input  logic [CWIDTH-1:0]        cmt_uses_rd,
    input  logic [CWIDTH*ARCH_W-1:0] cmt_rd_arch,
    input  logic [CWIDTH*PHYS_W-1:0] cmt_pd_new,
    input  logic [CWIDTH*PHYS_W-1:0] cmt_pd_old,
    input  logic                     flush_valid,
    output logic [PHYS_W:0]          free_count
);

    localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int FL_W     = $clog2(FL_DEPTH);
    localparam int PTR_W    = FL_W + 1;

    logic [PHYS_W-1:0] spec_rat_q [ARCH_REGS];
    logic [PHYS_W-1:0] spec_rat_d [ARCH_REGS];
    logic [PHYS_W-1:0] arch_rat_q [ARCH_REGS];
    logic [PHYS_W-1:0] arch_rat_d [ARCH_REGS];
    logic [PHYS_W-1:0] fl_q [FL_DEPTH];
    logic [PHYS_W-1:0] fl_d [FL_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W-1:0]  chead_q, chead_d;

    logic [WIDTH-1:0]  ren_wr;
    logic [PTR_W-1:0]  ren_nw;
    logic [PTR_W-1:0]  cmt_nw;
    logic [PTR_W-1:0]  avail;
    logic              ren_fire;
    logic [ARCH_W-1:0] rd_l  [WIDTH];
    logic [PHYS_W-1:0] new_l [WIDTH];
    logic [PHYS_W-1:0] old_l [WIDTH];
    logic [PHYS_W-1:0] p1_l  [WIDTH];
    logic [PHYS_W-1:0] p2_l  [WIDTH];
    logic [ARCH_W-1:0] rs1_t, rs2_t, rdj_t, crd_t;
    logic [FL_W-1:0]   slot_t, cslot_t;

    // Free entries come from registered pointers only, so entries freed this
    // cycle are not visible to the rename group of the same cycle.
    assign avail      = tail_q - head_q;
    assign free_count = {1'b0, avail};
    assign ren_ready  = !flush_valid && (avail >= ren_nw);
    assign ren_fire   = ren_ready && ren_valid[0];

    // Per-lane rename: allocation, source lookup and pd_old with bypass from
    // older lanes of the same group (highest older writer wins).
    always_comb begin
        ren_wr = '0;
        ren_nw = '0;
        rs1_t  = '0;
        rs2_t  = '0;
        rdj_t  = '0;
        slot_t = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rd_l[i]  = '0;
            new_l[i] = '0;
            old_l[i] = '0;
            p1_l[i]  = '0;
            p2_l[i]  = '0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            rd_l[i]   = ren_rd_arch[i*ARCH_W +: ARCH_W];
            rs1_t     = ren_rs1_arch[i*ARCH_W +: ARCH_W];
            rs2_t     = ren_rs2_arch[i*ARCH_W +: ARCH_W];
            ren_wr[i] = ren_valid[i] && ren_uses_rd[i] && (rd_l[i] != '0);
            p1_l[i]   = (rs1_t == '0) ? '0 : spec_rat_q[rs1_t];
            p2_l[i]   = (rs2_t == '0) ? '0 : spec_rat_q[rs2_t];
            old_l[i]  = spec_rat_q[rd_l[i]];
            for (int j = 0; j < i; j++) begin
                rdj_t = rd_l[j];
                if (ren_wr[j]) begin
                    // Writers never target x0, so a match implies a non-zero source.
                    if (rdj_t == rs1_t)   p1_l[i]  = new_l[j];
                    if (rdj_t == rs2_t)   p2_l[i]  = new_l[j];
                    if (rdj_t == rd_l[i]) old_l[i] = new_l[j];
                end
            end
            slot_t = head_q[FL_W-1:0] + ren_nw[FL_W-1:0];
            if (ren_wr[i]) begin
                new_l[i] = fl_q[slot_t];
                ren_nw   = ren_nw + 1'b1;
            end else begin
                old_l[i] = '0;
            end
        end
    end

    // Pack lane results onto the flat output buses.
    always_comb begin
        ren_rs1_phys = '0;
        ren_rs2_phys = '0;
        ren_pd_new   = '0;
        ren_pd_old   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ren_rs1_phys[i*PHYS_W +: PHYS_W] = p1_l[i];
            ren_rs2_phys[i*PHYS_W +: PHYS_W] = p2_l[i];
            ren_pd_new[i*PHYS_W +: PHYS_W]   = new_l[i];
            ren_pd_old[i*PHYS_W +: PHYS_W]   = old_l[i];
        end
    end

    // Next state: commits first, then rename fire; flush overrides speculative
    // state with the post-commit architectural view.
    always_comb begin
        spec_rat_d = spec_rat_q;
        arch_rat_d = arch_rat_q;
        fl_d       = fl_q;
        head_d     = head_q;
        cmt_nw     = '0;
        crd_t      = '0;
        cslot_t    = '0;
        for (int j = 0; j < CWIDTH; j++) begin
            crd_t   = cmt_rd_arch[j*ARCH_W +: ARCH_W];
            cslot_t = tail_q[FL_W-1:0] + cmt_nw[FL_W-1:0];
            if (cmt_valid[j] && cmt_uses_rd[j] && (crd_t != '0)) begin
                fl_d[cslot_t]     = cmt_pd_old[j*PHYS_W +: PHYS_W];
                arch_rat_d[crd_t] = cmt_pd_new[j*PHYS_W +: PHYS_W];
                cmt_nw            = cmt_nw + 1'b1;
            end
        end
        tail_d  = tail_q + cmt_nw;
        chead_d = chead_q + cmt_nw;
        if (ren_fire) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (ren_wr[i]) spec_rat_d[rd_l[i]] = new_l[i];
            end
            head_d = head_q + ren_nw;
        end
        if (flush_valid) begin
            spec_rat_d = arch_rat_d;
            head_d     = chead_d;
        end
    end

    // State registers; reset gives the identity map and a full free list.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ARCH_REGS; r++) begin
                spec_rat_q[r] <= PHYS_W'(r);
                arch_rat_q[r] <= PHYS_W'(r);
            end
            for (int k = 0; k < FL_DEPTH; k++) begin
                fl_q[k] <= PHYS_W'(ARCH_REGS + k);
            end
            head_q  <= '0;
            tail_q  <= PTR_W'(FL_DEPTH);
            chead_q <= '0;
        end else begin
            spec_rat_q <= spec_rat_d;
            arch_rat_q <= arch_rat_d;
            fl_q       <= fl_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            chead_q    <= chead_d;
        end
    end

    // Every physical register is either mapped architecturally or free.
    a_fl_invariant: assert property (@(posedge clk) disable iff (!rst_n)
        (tail_q - chead_q) == PTR_W'(FL_DEPTH));

    // Retirement can never return more entries than the list holds.
    a_fl_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (int'(avail) + int'(cmt_nw)) <= FL_DEPTH);

endmodule

// File: tb/tb_rename_map_nw.sv
// Directed bench for rename_map_nw with hand-computed expected mappings.
module tb_rename_map_nw;

    localparam int ARCH_REGS = 32;
    localparam int PHYS_REGS = 64;
    localparam int WIDTH     = 2;
    localparam int CWIDTH    = 2;
    localparam int ARCH_W    = 5;
    localparam int PHYS_W    = 6;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [WIDTH-1:0]         ren_valid;
    logic                     ren_ready;
    logic [WIDTH-1:0]         ren_uses_rd;
    logic [WIDTH*ARCH_W-1:0]  ren_rd_arch;
    logic [WIDTH*ARCH_W-1:0]  ren_rs1_arch;
    logic [WIDTH*ARCH_W-1:0]  ren_rs2_arch;
    logic [WIDTH*PHYS_W-1:0]  ren_rs1_phys;
    logic [WIDTH*PHYS_W-1:0]  ren_rs2_phys;
    logic [WIDTH*PHYS_W-1:0]  ren_pd_new;
    logic [WIDTH*PHYS_W-1:0]  ren_pd_old;
    logic [CWIDTH-1:0]        cmt_valid;
    logic [CWIDTH-1:0]        cmt_uses_rd;
    logic [CWIDTH*ARCH_W-1:0] cmt_rd_arch;
    logic [CWIDTH*PHYS_W-1:0] cmt_pd_new;
    logic [CWIDTH*PHYS_W-1:0] cmt_pd_old;
    logic                     flush_valid;
    logic [PHYS_W:0]          free_count;

    int n_vec = 0;
    int n_err = 0;

    rename_map_nw #(
        .ARCH_REGS(ARCH_REGS), .PHYS_REGS(PHYS_REGS), .WIDTH(WIDTH), .CWIDTH(CWIDTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ren_valid(ren_valid), .ren_ready(ren_ready), .ren_uses_rd(ren_uses_rd),
        .ren_rd_arch(ren_rd_arch), .ren_rs1_arch(ren_rs1_arch), .ren_rs2_arch(ren_rs2_arch),
        .ren_rs1_phys(ren_rs1_phys), .ren_rs2_phys(ren_rs2_phys),
        .ren_pd_new(ren_pd_new), .ren_pd_old(ren_pd_old),
        .cmt_valid(cmt_valid), .cmt_uses_rd(cmt_uses_rd), .cmt_rd_arch(cmt_rd_arch),
        .cmt_pd_new(cmt_pd_new), .cmt_pd_old(cmt_pd_old),
        .flush_valid(flush_valid), .free_count(free_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ren_valid = '0; ren_uses_rd = '0; ren_rd_arch = '0;
        ren_rs1_arch = '0; ren_rs2_arch = '0;
        cmt_valid = '0; cmt_uses_rd = '0; cmt_rd_arch = '0;
        cmt_pd_new = '0; cmt_pd_old = '0; flush_valid = 1'b0;
    endtask

    task automatic set_ren(input int l, input bit v, input bit u, input int rd,
                           input int rs1, input int rs2);
        ren_valid[l]                   = v;
        ren_uses_rd[l]                 = u;
        ren_rd_arch[l*ARCH_W +: ARCH_W]  = ARCH_W'(rd);
        ren_rs1_arch[l*ARCH_W +: ARCH_W] = ARCH_W'(rs1);
        ren_rs2_arch[l*ARCH_W +: ARCH_W] = ARCH_W'(rs2);
    endtask

    task automatic set_cmt(input int l, input int rd, input int pn, input int po);
        cmt_valid[l]                    = 1'b1;
        cmt_uses_rd[l]                  = 1'b1;
        cmt_rd_arch[l*ARCH_W +: ARCH_W] = ARCH_W'(rd);
        cmt_pd_new[l*PHYS_W +: PHYS_W]  = PHYS_W'(pn);
        cmt_pd_old[l*PHYS_W +: PHYS_W]  = PHYS_W'(po);
    endtask

    function automatic int rs1p(input int l); return int'(ren_rs1_phys[l*PHYS_W +: PHYS_W]); endfunction
    function automatic int rs2p(input int l); return int'(ren_rs2_phys[l*PHYS_W +: PHYS_W]); endfunction
    function automatic int pnew(input int l); return int'(ren_pd_new[l*PHYS_W +: PHYS_W]);   endfunction
    function automatic int pold(input int l); return int'(ren_pd_old[l*PHYS_W +: PHYS_W]);   endfunction

    // Finish the current cycle: wait for the edge, then move off it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int prev10, prev11, e0, e1;
        idle();
        rst_n = 1'b0;
        set_ren(0, 1'b1, 1'b0, 0, 5, 0);
        #12;
        check("rst_free_count", int'(free_count), 32);
        check("rst_rs1_x5", rs1p(0), 5);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Plain read after reset
        idle();
        set_ren(0, 1'b1, 1'b0, 0, 5, 0);
        @(negedge clk);
        check("read_rs1_x5", rs1p(0), 5);
        check("read_rs2_x0", rs2p(0), 0);
        check("read_free", int'(free_count), 32);
        check("read_ready", int'(ren_ready), 1);
        step();

        // RAW/WAW bypass inside one group
        idle();
        set_ren(0, 1'b1, 1'b1, 3, 1, 2);
        set_ren(1, 1'b1, 1'b1, 3, 3, 0);
        @(negedge clk);
        check("grp_l0_rs1", rs1p(0), 1);
        check("grp_l0_new", pnew(0), 32);
        check("grp_l0_old", pold(0), 3);
        check("grp_l1_rs1", rs1p(1), 32);
        check("grp_l1_new", pnew(1), 33);
        check("grp_l1_old", pold(1), 32);
        step();
        idle();
        set_ren(0, 1'b1, 1'b0, 0, 3, 0);
        @(negedge clk);
        check("grp_free_after", int'(free_count), 30);
        check("grp_spec_x3", rs1p(0), 33);
        step();

        // Retire both renames of x3
        idle();
        set_cmt(0, 3, 32, 3);
        set_cmt(1, 3, 33, 32);
        @(negedge clk);
        check("cmt_free_same_cycle", int'(free_count), 30);
        step();
        idle();
        @(negedge clk);
        check("cmt_free_after", int'(free_count), 32);
        step();

        // Rename x7 then flush with nothing committed
        idle();
        set_ren(0, 1'b1, 1'b1, 7, 0, 0);
        @(negedge clk);
        check("x7_new", pnew(0), 34);
        check("x7_old", pold(0), 7);
        step();
        idle();
        set_ren(0, 1'b1, 1'b1, 8, 7, 0);
        flush_valid = 1'b1;
        @(negedge clk);
        check("pre_flush_rs1_x7", rs1p(0), 34);
        check("pre_flush_free", int'(free_count), 31);
        check("flush_ready", int'(ren_ready), 0);
        step();
        idle();
        set_ren(0, 1'b1, 1'b1, 7, 7, 3);
        @(negedge clk);
        check("post_flush_rs1_x7", rs1p(0), 7);
        check("post_flush_rs2_x3", rs2p(0), 33);
        check("post_flush_free", int'(free_count), 32);
        check("post_flush_realloc", pnew(0), 34);
        step();

        // Rename x9, then flush together with the commits of x7 and x9
        idle();
        set_ren(0, 1'b1, 1'b1, 9, 0, 0);
        @(negedge clk);
        check("x9_new", pnew(0), 35);
        check("x9_old", pold(0), 9);
        step();
        idle();
        set_ren(0, 1'b1, 1'b1, 12, 0, 0);
        set_cmt(0, 7, 34, 7);
        set_cmt(1, 9, 35, 9);
        flush_valid = 1'b1;
        @(negedge clk);
        check("flcmt_ready", int'(ren_ready), 0);
        check("flcmt_free_same", int'(free_count), 30);
        step();
        idle();
        set_ren(0, 1'b1, 1'b0, 0, 9, 7);
        @(negedge clk);
        check("flcmt_spec_x9", rs1p(0), 35);
        check("flcmt_spec_x7", rs2p(0), 34);
        check("flcmt_free_after", int'(free_count), 32);
        step();

        // Drain the free list with two-writer groups; freed regs come last
        prev10 = 10;
        prev11 = 11;
        for (int g = 0; g < 16; g++) begin
            idle();
            set_ren(0, 1'b1, 1'b1, 10, 0, 0);
            set_ren(1, 1'b1, 1'b1, 11, 10, 0);
            e0 = (g < 14) ? 36 + 2*g : ((g == 14) ? 3 : 7);
            e1 = (g < 14) ? 37 + 2*g : ((g == 14) ? 32 : 9);
            @(negedge clk);
            check("fill_ready", int'(ren_ready), 1);
            check("fill_free", int'(free_count), 32 - 2*g);
            check("fill_l0_new", pnew(0), e0);
            check("fill_l1_new", pnew(1), e1);
            check("fill_l0_old", pold(0), prev10);
            check("fill_l1_old", pold(1), prev11);
            check("fill_l1_rs1", rs1p(1), e0);
            prev10 = e0;
            prev11 = e1;
            step();
        end

        // Empty list: a writer stalls, an x0-only group still goes
        idle();
        set_ren(0, 1'b1, 1'b1, 12, 0, 0);
        @(negedge clk);
        check("empty_free", int'(free_count), 0);
        check("empty_ready_1w", int'(ren_ready), 0);
        step();
        idle();
        set_ren(0, 1'b1, 1'b1, 0, 11, 0);
        set_ren(1, 1'b1, 1'b0, 0, 10, 0);
        @(negedge clk);
        check("empty_ready_x0", int'(ren_ready), 1);
        check("x0_new", pnew(0), 0);
        check("x0_old", pold(0), 0);
        check("empty_rs1_x11", rs1p(0), 9);
        check("empty_rs1_x10", rs1p(1), 7);
        step();

        // Reset mid-run discards everything
        idle();
        set_ren(0, 1'b1, 1'b0, 0, 10, 0);
        flush_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #3;
        check("rerst_free", int'(free_count), 32);
        check("rerst_rs1_x10", rs1p(0), 10);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rename_map_nw.md
Name: rename_map_nw

Overview:
- N-wide rename/retire map for the out-of-order core, sitting between decode/dispatch and the ROB.
- Successor to the single-lane rename front end: renames up to WIDTH instructions per cycle with intra-group RAW/WAW bypass, and retires up to CWIDTH per cycle.
- Holds a speculative RAT, an architectural RAT and a circular free list.
- Flush restores speculative state in one cycle from the architectural RAT and a committed free-list pointer, with no ROB walk.

Parameters:
- ARCH_REGS, 32, architectural registers.
- PHYS_REGS, 64, physical registers. PHYS_REGS-ARCH_REGS (FL_DEPTH) must be a power of two and >= WIDTH.
- WIDTH, 2, rename lanes per cycle.
- CWIDTH, 2, commit lanes per cycle.
- ARCH_W, $clog2(ARCH_REGS), architectural index width.
- PHYS_W, $clog2(PHYS_REGS), physical index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ren_valid  in  WIDTH  per-lane valid; contiguous from lane 0
- ren_ready  out  1  whole group accepted this cycle
- ren_uses_rd  in  WIDTH  lane writes rd
- ren_rd_arch  in  WIDTH*ARCH_W  destination arch reg per lane
- ren_rs1_arch  in  WIDTH*ARCH_W  source 1 per lane
- ren_rs2_arch  in  WIDTH*ARCH_W  source 2 per lane
- ren_rs1_phys  out  WIDTH*PHYS_W  renamed source 1 (combinational)
- ren_rs2_phys  out  WIDTH*PHYS_W  renamed source 2 (combinational)
- ren_pd_new  out  WIDTH*PHYS_W  allocated dest per lane
- ren_pd_old  out  WIDTH*PHYS_W  previous mapping of rd, for the ROB
- cmt_valid  in  CWIDTH  per-lane retire valid, contiguous, program order
- cmt_uses_rd  in  CWIDTH  retiring lane wrote rd
- cmt_rd_arch  in  CWIDTH*ARCH_W  retiring rd
- cmt_pd_new  in  CWIDTH*PHYS_W  retiring pd_new
- cmt_pd_old  in  CWIDTH*PHYS_W  retiring pd_old, returned to free list
- flush_valid  in  1  squash all uncommitted renames
- free_count  out  PHYS_W+1  free entries available (tail-head)

Behaviour:
Effective write-enable:
- Rename lane writes iff ren_valid[i] & ren_uses_rd[i] & rd_arch!=0.
- Commit lane writes iff cmt_valid[j] & cmt_uses_rd[j] & rd_arch!=0.
- An x0 destination never allocates. Its pd_new and pd_old outputs are 0.

Handshake:
- ren_ready = !flush_valid & (free_count >= popcount of rename writes).
- Fire = ren_ready & ren_valid[0]. The group is atomic: no partial acceptance.
- ren_ready is independent of ren_valid aside from the popcount.

Free-list allocation:
- Lane i takes pd_new = fl[(head + k) mod FL_DEPTH], where k = number of writing lanes below i.

Source lookup:
- Sources read the spec RAT.
- Override: take pd_new of the highest writing lane j<i whose rd equals the source.
- Source x0 always returns 0.

pd_old:
- Spec RAT[rd], overridden by the highest earlier writing lane with the same rd (WAW).

On fire (next clock edge):
- head += writes.
- Spec RAT[rd]=pd_new per writing lane; for duplicate rd, the highest lane wins.

Commit:
- Always accepted; there is no ready signal.
- Writing lanes, in lane order: fl[tail]=pd_old, then tail++.
- archRAT[rd]=pd_new; later lane wins on equal rd.
- commit_head += writes.

Pointers:
- head, tail and commit_head are log2(FL_DEPTH)+1 bits and wrap naturally.
- Invariant: tail-commit_head == FL_DEPTH always. Assert it.
- Assert that a commit never pushes beyond FL_DEPTH.

Flush:
- Rename is blocked that cycle. Same-cycle commits still apply.
- Next cycle: specRAT = archRAT including same-cycle commit updates; head = commit_head including same-cycle increments.

Same cycle:
- Rename fire and commit in the same cycle are independent.
- A free list freed this cycle is not allocatable until the next cycle.
- free_count uses registered pointers.

Reset (asynchronous, active-low):
- specRAT[r] = archRAT[r] = r.
- fl[k] = ARCH_REGS+k.
- head = commit_head = 0; tail = FL_DEPTH.
- free_count = FL_DEPTH.
- Outputs held at these values while rst_n is low.
- Reset mid-flush discards all state.

Test Plan:
- Reset, then read r5 on lane0 -> rs1_phys=5, free_count=32, ren_ready=1.
- Group {lane0: x3=.., lane1: rs1=x3, rd=x3} -> lane0 pd_new=32, pd_old=3; lane1 rs1_phys=32, pd_new=33, pd_old=32; next cycle free_count=30, spec x3->33.
- Rename 32 writers until free_count=0 -> ren_ready=0 on a 1-write group; ren_ready stays 1 for a group with rd=x0 only.
- Commit lane0 (x3, new=32, old=3) and lane1 (x3, new=33, old=32) -> tail+=2, archRAT x3=33, free_count +2 next cycle; 3 and 32 reappear at allocation order end.
- Rename x7 (pd 34), then flush with no commit -> next cycle rs1(x7)=7, head rewinds, free_count returns to the pre-rename value, 34 reallocated first.
- Flush in the same cycle as a commit of x9 -> next cycle spec x9 equals the committed pd_new; ren_ready=0 during the flush cycle.
